// File: rtl/hint_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : hint_stream_loader
// Purpose  : Upstream feeder for the hint decoder. Assembles the witness hint
//            byte stream into 72-bit hint words, most significant byte first,
//            and buffers completed words in a small FIFO. The head word is
//            presented on raw_hint with a pop handshake. An empty FIFO shows
//            an all-zero word, so the downstream valid bit reads 0.
//
// Ports    : clk            clock, rising edge
//            rst_n          synchronous active-low reset
//            in_byte/in_valid/in_ready   byte input handshake
//            flush          drop partial word and all buffered words
//            raw_hint       FIFO head word, 0 when empty
//            hint_avail     FIFO non-empty
//            hint_pop       consumer takes the head word this cycle
//            fill_count     number of buffered words, 0..DEPTH
//            byte_phase     bytes of the current partial word accepted, 0..8
//            underflow_err  sticky, set by a pop while empty
//            hints_loaded   saturating count of words pushed since reset
//
// Revision : 1.0  initial release
// ============================================================================
module hint_stream_loader #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [71:0]             raw_hint,
    output logic                    hint_avail,
    input  logic                    hint_pop,
    output logic [$clog2(DEPTH):0]  fill_count,
    output logic [3:0]              byte_phase,
    output logic                    underflow_err,
    output logic [CNT_W-1:0]        hints_loaded
);

    localparam int              c_PTR_W      = $clog2(DEPTH);
    localparam logic [3:0]      c_LAST_PHASE = 4'd8;
    localparam logic [c_PTR_W:0] c_FULL      = (c_PTR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Bytes 0..7 of the word under assembly; byte 8 never needs storing
    // because it completes the word and goes straight into the FIFO.
    logic [63:0]        r_partial;
    logic [3:0]         r_phase;
    logic [71:0]        r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               r_underflow;
    logic [CNT_W-1:0]   r_loaded;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic        w_accept;
    logic        w_store;
    logic        w_push;
    logic        w_pop;
    logic        w_underflow;
    logic [71:0] w_word;

    // Ready depends only on registered state: a pop in the same cycle does
    // not free a slot for the completing byte.
    assign in_ready    = (r_phase != c_LAST_PHASE) || (r_count != c_FULL);
    assign hint_avail  = (r_count != '0);

    assign w_accept    = in_valid && in_ready;
    // A byte that handshakes during a flush is discarded.
    assign w_store     = w_accept && !flush;
    assign w_push      = w_store && (r_phase == c_LAST_PHASE);
    assign w_pop       = hint_pop && hint_avail && !flush;
    assign w_underflow = hint_pop && !hint_avail && !flush;

    assign w_word      = {r_partial, in_byte};

    // ------------------------------------------------------------------
    // Partial word assembly: byte k lands in word bits [71-8k : 64-8k],
    // i.e. partial bits [63-8k : 56-8k].
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_partial <= '0;
        end else if (w_store) begin
            for (int i = 0; i < 8; i++) begin
                if (r_phase == 4'(i)) begin
                    r_partial[8*(7-i) +: 8] <= in_byte;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase <= '0;
        end else if (flush) begin
            r_phase <= '0;
        end else if (w_accept) begin
            if (r_phase == c_LAST_PHASE) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage; contents need no reset because raw_hint is gated by
    // hint_avail and entries are always written before they are read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Status: sticky underflow survives flush; only reset clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_underflow <= 1'b0;
        end else if (w_underflow) begin
            r_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_loaded <= '0;
        end else if (w_push && !(&r_loaded)) begin
            r_loaded <= r_loaded + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign raw_hint      = hint_avail ? r_mem[r_rd_ptr] : '0;
    assign fill_count    = r_count;
    assign byte_phase    = r_phase;
    assign underflow_err = r_underflow;
    assign hints_loaded  = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_hint_stream_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_hint_stream_loader
// Purpose  : Self-checking bench for hint_stream_loader. A queue-based model
//            tracks buffered words and the partial word; popped words are
//            queued as expectations and matched by an independent monitor.
// Revision : 1.0  initial release
// ============================================================================
module tb_hint_stream_loader;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [71:0]       raw_hint;
    logic              hint_avail;
    logic              hint_pop;
    logic [CW-1:0]     fill_count;
    logic [3:0]        byte_phase;
    logic              underflow_err;
    logic [CNT_W-1:0]  hints_loaded;

    hint_stream_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .flush         (flush),
        .raw_hint      (raw_hint),
        .hint_avail    (hint_avail),
        .hint_pop      (hint_pop),
        .fill_count    (fill_count),
        .byte_phase    (byte_phase),
        .underflow_err (underflow_err),
        .hints_loaded  (hints_loaded)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [71:0] m_q[$];
    logic [71:0] exp_q[$];
    logic [7:0]  m_part [8];
    int          m_phase;
    bit          m_uf;
    int          m_loaded;
    bit          m_live;

    int vectors;
    int miscompares;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !(m_phase == 8 && m_q.size() == DEPTH);
    endfunction

    task automatic check_state();
        chk("in_ready",      72'(in_ready),      72'(m_ready()));
        chk("hint_avail",    72'(hint_avail),    72'(m_q.size() > 0));
        chk("raw_hint",      raw_hint,           (m_q.size() > 0) ? m_q[0] : 72'h0);
        chk("fill_count",    72'(fill_count),    72'(m_q.size()));
        chk("byte_phase",    72'(byte_phase),    72'(m_phase));
        chk("underflow_err", 72'(underflow_err), 72'(m_uf));
        chk("hints_loaded",  72'(hints_loaded),  72'(m_loaded));
    endtask

    task automatic model_step(input logic v, input logic [7:0] b, input logic p,
                              input logic f, input logic rn);
        bit          acc;
        logic [71:0] w;
        if (!rn) begin
            m_q.delete();
            m_phase  = 0;
            m_uf     = 1'b0;
            m_loaded = 0;
            m_live   = 1'b1;
            return;
        end
        if (!m_live) return;
        if (f) begin
            m_q.delete();
            m_phase = 0;
            return;
        end
        acc = v && m_ready();
        if (p) begin
            if (m_q.size() > 0) exp_q.push_back(m_q.pop_front());
            else                m_uf = 1'b1;
        end
        if (acc) begin
            if (m_phase == 8) begin
                w = '0;
                for (int k = 0; k < 8; k++) w = {w[63:0], m_part[k]};
                w = {w[63:0], b};
                m_q.push_back(w);
                m_phase = 0;
                if (m_loaded < (1 << CNT_W) - 1) m_loaded++;
            end else begin
                m_part[m_phase] = b;
                m_phase++;
            end
        end
    endtask

    // Inputs change 2 time units after the rising edge; state is checked
    // and the model advanced at the falling edge.
    task automatic step(input logic v, input logic [7:0] b, input logic p,
                        input logic f, input logic rn);
        in_valid = v;
        in_byte  = b;
        hint_pop = p;
        flush    = f;
        rst_n    = rn;
        @(negedge clk);
        if (m_live) check_state();
        model_step(v, b, p, f, rn);
        @(posedge clk);
        #2;
    endtask

    task automatic send_word(input logic [71:0] w, input logic pop_last);
        logic [71:0] t;
        t = w;
        for (int k = 0; k < 9; k++) begin
            step(1'b1, t[71:64], (k == 8) ? pop_last : 1'b0, 1'b0, 1'b1);
            t = t << 8;
        end
    endtask

    function automatic logic [7:0] rbyte();
        return 8'($urandom_range(0, 255));
    endfunction

    function automatic logic [71:0] rword(input logic [7:0] meta);
        return {meta, 32'($urandom), 32'($urandom)};
    endfunction

    // ------------------------------------------------------------------
    // Monitor: every pop the DUT performs must match the next expected word.
    // ------------------------------------------------------------------
    always begin
        logic [71:0] w;
        @(negedge clk);
        #1;
        if (rst_n === 1'b1 && flush === 1'b0 && hint_pop === 1'b1 && hint_avail === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_word: DUT popped %h but no word was expected", raw_hint);
            end else begin
                w = exp_q.pop_front();
                chk("pop_word", raw_hint, w);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        m_live      = 1'b0;
        m_phase     = 0;
        m_uf        = 1'b0;
        m_loaded    = 0;
        for (int k = 0; k < 8; k++) m_part[k] = '0;
        in_valid = 1'b0;
        in_byte  = '0;
        hint_pop = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #2;
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("reset_raw_hint", raw_hint, 72'h0);
        chk("reset_fill",     72'(fill_count), 72'h0);

        // Load and pop one word
        send_word(72'h87_00401000_DEADBEEF, 1'b0);
        chk("t1_raw_hint", raw_hint, 72'h87_00401000_DEADBEEF);
        chk("t1_fill",     72'(fill_count), 72'd1);
        chk("t1_loaded",   72'(hints_loaded), 72'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("t1_after_pop", raw_hint, 72'h0);
        chk("t1_avail",     72'(hint_avail), 72'h0);

        // Fill to DEPTH, then stall the completing byte
        for (int i = 0; i < DEPTH; i++) send_word(rword(8'(8'h80 | i)), 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, rbyte(), 1'b0, 1'b0, 1'b1);
        chk("t2_ready_low", 72'(in_ready), 72'h0);
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        chk("t2_ready_back", 72'(in_ready), 72'h1);
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Simultaneous push/pop at fill 2, wrapping the pointers
        send_word(72'd100, 1'b0);
        send_word(72'd101, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send_word(72'(i), 1'b1);
            chk("t3_fill_steady", 72'(fill_count), 72'd2);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

        // Pop while empty
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("t4_underflow", 72'(underflow_err), 72'h1);
        chk("t4_fill",      72'(fill_count), 72'h0);
        send_word(rword(8'h11), 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("t4_uf_sticky", 72'(underflow_err), 72'h1);

        // Flush with byte_phase 5, fill 3
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t5_uf_cleared", 72'(underflow_err), 72'h0);
        for (int i = 0; i < 3; i++) send_word(rword(8'(i)), 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, rbyte(), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
        chk("t5_phase",  72'(byte_phase), 72'h0);
        chk("t5_fill",   72'(fill_count), 72'h0);
        chk("t5_raw",    raw_hint, 72'h0);
        chk("t5_loaded", 72'(hints_loaded), 72'd3);
        send_word(72'hC3_12345678_9ABCDEF0, 1'b0);
        chk("t5_reload", raw_hint, 72'hC3_12345678_9ABCDEF0);

        // Reset mid-word with in_valid held high
        for (int k = 0; k < 4; k++) step(1'b1, rbyte(), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        chk("t6_phase", 72'(byte_phase), 72'h0);
        chk("t6_raw",   raw_hint, 72'h0);
        send_word(72'h01_AABBCCDD_11223344, 1'b0);
        chk("t6_clean", raw_hint, 72'h01_AABBCCDD_11223344);

        // Randomised traffic: light pops first (fills and saturates), then heavy
        for (int n = 0; n < 3000; n++) begin
            logic v, p, f, rn;
            v  = ($urandom_range(0, 9) < 7);
            p  = (n < 1500) ? ($urandom_range(0, 99) < 5) : ($urandom_range(0, 9) < 3);
            f  = ($urandom_range(0, 199) < 2);
            rn = !($urandom_range(0, 799) == 0);
            step(v, rbyte(), p, f, rn);
        end

        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("scoreboard_drained", 72'(exp_q.size()), 72'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
